// File: rtl/down_counter_sec_if.sv
// rtl/down_counter_sec_if.sv - control/data bundle between the seconds stage and its driver
interface down_counter_sec_if;
    logic       tick;
    logic       pb_start;
    logic       pb_clr;
    logic       set_en;
    logic [3:0] set_s1;
    logic [3:0] set_s0;
    logic       min_zero;
    logic [3:0] sec_s1;
    logic [3:0] sec_s0;
    logic       de_en;
    logic       br_m0;
    logic       done;

    modport master (
        output tick, pb_start, pb_clr, set_en, set_s1, set_s0, min_zero,
        input  sec_s1, sec_s0, de_en, br_m0, done
    );

    modport slave (
        input  tick, pb_start, pb_clr, set_en, set_s1, set_s0, min_zero,
        output sec_s1, sec_s0, de_en, br_m0, done
    );
endinterface

// File: rtl/down_counter_sec.sv
// rtl/down_counter_sec.sv - BCD seconds down counter with run/pause/done control FSM
module down_counter_sec #(
    parameter int TENS_MAX = 5,
    parameter int ONES_MAX = 9
) (
    input  logic               clk_d,
    input  logic               rst_n,
    down_counter_sec_if.slave  bus
);
    localparam logic [3:0] L_TENS = 4'(TENS_MAX);
    localparam logic [3:0] L_ONES = 4'(ONES_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_s1;
    logic [3:0] r_s0;
    logic [3:0] w_s1_nxt;
    logic [3:0] w_s0_nxt;
    logic       w_sec_zero;
    logic       w_all_zero;

    assign w_sec_zero = (r_s1 == 4'd0) && (r_s0 == 4'd0);
    assign w_all_zero = w_sec_zero && bus.min_zero;

    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_s1    <= 4'd0;
            r_s0    <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_s1    <= w_s1_nxt;
            r_s0    <= w_s0_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s1_nxt    = r_s1;
        w_s0_nxt    = r_s0;
        if (bus.pb_clr) begin
            w_state_nxt = S_IDLE;
            w_s1_nxt    = 4'd0;
            w_s0_nxt    = 4'd0;
        end else if (bus.set_en && (r_state == S_IDLE || r_state == S_PAUSE)) begin
            // Out-of-range loads saturate so the digits always stay legal BCD
            w_s1_nxt = (bus.set_s1 > L_TENS) ? L_TENS : bus.set_s1;
            w_s0_nxt = (bus.set_s0 > L_ONES) ? L_ONES : bus.set_s0;
        end else begin
            case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (bus.pb_start && !w_all_zero)
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (bus.pb_start) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_all_zero) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.tick) begin
                        if (r_s0 != 4'd0) begin
                            w_s0_nxt = r_s0 - 4'd1;
                        end else if (r_s1 != 4'd0) begin
                            w_s1_nxt = r_s1 - 4'd1;
                            w_s0_nxt = L_ONES;
                        end else begin
                            w_s1_nxt = L_TENS;
                            w_s0_nxt = L_ONES;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.pb_start)
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.sec_s1 = r_s1;
    assign bus.sec_s0 = r_s0;
    assign bus.de_en  = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    // Combinational so the minute stage steps on the same edge as the 00->59 wrap
    assign bus.br_m0  = (r_state == S_RUN) && bus.tick && w_sec_zero && !bus.min_zero;
endmodule

// File: tb/tb_down_counter_sec.sv
// tb/tb_down_counter_sec.sv - directed and random checks of down_counter_sec against a seconds-count model
module tb_down_counter_sec;
    logic clk_d = 1'b0;
    logic rst_n = 1'b0;
    down_counter_sec_if bus ();

    down_counter_sec #(.TENS_MAX(5), .ONES_MAX(9)) dut (
        .clk_d (clk_d),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_d = ~clk_d;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int m_secs  = 0;
    int m_st    = M_IDLE;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step(input bit rst, input bit clr, input bit set, input int s1, input int s0,
                        input bit start, input bit tk, input bit mz);
        int exp_br;
        @(negedge clk_d);
        rst_n        = ~rst;
        bus.pb_clr   = clr;
        bus.set_en   = set;
        bus.set_s1   = 4'(s1);
        bus.set_s0   = 4'(s0);
        bus.pb_start = start;
        bus.tick     = tk;
        bus.min_zero = mz;
        #1;
        exp_br = (m_st == M_RUN && tk && m_secs == 0 && !mz) ? 1 : 0;
        chk("br_m0", int'(bus.br_m0), exp_br);
        @(posedge clk_d);
        if (rst) begin
            m_secs = 0; m_st = M_IDLE;
        end else if (clr) begin
            m_secs = 0; m_st = M_IDLE;
        end else if (set && (m_st == M_IDLE || m_st == M_PAUSE)) begin
            m_secs = min_i(s1, 5) * 10 + min_i(s0, 9);
        end else if (start) begin
            if (m_st == M_RUN)       m_st = M_PAUSE;
            else if (m_st == M_DONE) m_st = M_IDLE;
            else if (!(m_secs == 0 && mz)) m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (m_secs == 0 && mz) m_st = M_DONE;
            else if (tk) m_secs = (m_secs + 59) % 60;
        end
        #1;
        chk("sec_s1", int'(bus.sec_s1), m_secs / 10);
        chk("sec_s0", int'(bus.sec_s0), m_secs % 10);
        chk("de_en",  int'(bus.de_en),  (m_st == M_RUN) ? 1 : 0);
        chk("done",   int'(bus.done),   (m_st == M_DONE) ? 1 : 0);
    endtask

    task automatic idle(input bit tk, input bit mz);
        step(0, 0, 0, 0, 0, 0, tk, mz);
    endtask

    initial begin
        bus.tick = 0; bus.pb_start = 0; bus.pb_clr = 0; bus.set_en = 0;
        bus.set_s1 = 0; bus.set_s0 = 0; bus.min_zero = 0;

        // reset, load 32, run, three ticks
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) idle(1, 0);
        chk("dir_29", int'(bus.sec_s1) * 10 + int'(bus.sec_s0), 29);

        // wrap 00 -> 59 with borrow
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1, 0);
        chk("dir_59", int'(bus.sec_s1) * 10 + int'(bus.sec_s0), 59);

        // 01 with minutes at zero -> DONE
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        idle(1, 1);
        idle(0, 1);
        chk("dir_done", int'(bus.done), 1);
        idle(1, 1);
        idle(1, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);

        // saturating load, ignored in RUN
        step(0, 0, 1, 7, 12, 0, 0, 0);
        chk("dir_sat", int'(bus.sec_s1) * 10 + int'(bus.sec_s0), 59);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0);

        // pause beats tick at 45
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 4, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) idle(1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1, 0);
        chk("dir_44", int'(bus.sec_s1) * 10 + int'(bus.sec_s0), 44);

        // reset mid-count, clear in PAUSE
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 3, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 14) == 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
